sm_hex_scanner: RTL and testbench



---
 rtl/sm_hex_scanner.sv | 131 +++++++++++++
 tb/tb_sm_hex_scanner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sm_hex_scanner.sv
// -----------------------------------------------------------------------------
// sm_hex_scanner
//
// Multiplexed seven-segment driver for a common-anode hex display. Shows the
// DIGITS nibbles of `data` one digit at a time, dwelling 2^PRESCALE_W clocks
// per digit. The displayed value is snapshotted once per refresh frame so a
// frame never mixes two input values.
//
// Ports:
//   clk       board clock
//   rst_n     asynchronous active-low reset
//   data      value to display; nibble i drives digit i, digit 0 is rightmost
//   hold      freeze: snapshot is not reloaded at frame boundaries
//   blank_lz  enable leading-zero blanking (digit 0 is never blanked)
//   seg_n     active-low segments {g,f,e,d,c,b,a}
//   dp_n      active-low decimal point, lit on digit 0 while frozen
//   an_n      active-low digit enables, all off during the guard time
//   frame     one-clock pulse in the first clock of each frame (idx == 0)
//
// All outputs are registered from the previous clock's cnt/idx/snap and
// inputs, giving one clock of latency.
// -----------------------------------------------------------------------------
module sm_hex_scanner #(
    parameter int DIGITS     = 8,
    parameter int PRESCALE_W = 16,
    parameter int GUARD      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  hold,
    input  logic                  blank_lz,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame
);

    localparam int                    IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [PRESCALE_W-1:0] GUARD_CNT = PRESCALE_W'(GUARD);

    // Active-low hex font, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    logic [PRESCALE_W-1:0] cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   snap;

    logic                  dwell_end;
    logic                  frame_evt;
    logic [DIGITS-1:0]     zero_above;
    logic                  zero_run;
    logic [3:0]            nibble;
    logic                  blank_digit;

    assign dwell_end = &cnt;
    assign frame_evt = dwell_end && (idx == IDX_LAST);

    // zero_above[i] is set when snap nibbles i..DIGITS-1 are all zero, built
    // as a running AND from the most significant digit downward.
    always_comb begin
        zero_above = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (snap[4*i +: 4] == 4'h0);
            zero_above[i] = zero_run;
        end
    end

    assign nibble      = snap[4*int'(idx) +: 4];
    assign blank_digit = blank_lz && (idx != '0) && zero_above[idx];

    // Scan state: prescaler, digit index and per-frame snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            idx  <= '0;
            snap <= '0;
        end else begin
            cnt <= cnt + PRESCALE_W'(1);
            if (dwell_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            // hold is sampled in the boundary clock itself, so a rising hold
            // in that clock already blocks the load.
            if (frame_evt && !hold) begin
                snap <= data;
            end
        end
    end

    // Output register stage: one clock behind the scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= '1;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
            frame <= 1'b0;
        end else begin
            // Only the anodes are gated by the guard window; segments keep
            // changing underneath so the new digit is settled when lit.
            an_n  <= (cnt < GUARD_CNT) ? '1 : ~(DIGITS'(1) << idx);
            seg_n <= blank_digit ? 7'h7F : hex_decode(nibble);
            dp_n  <= ~(hold && (idx == '0));
            frame <= frame_evt;
        end
    end

endmodule

// File: tb/tb_sm_hex_scanner.sv
module tb_sm_hex_scanner;

    localparam int DIGITS     = 8;
    localparam int PRESCALE_W = 2;
    localparam int GUARD      = 1;
    localparam int DWELL      = 1 << PRESCALE_W;
    localparam int FRAME_LEN  = DIGITS * DWELL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data = 32'h0;
    logic        hold = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;
    logic        frame;

    sm_hex_scanner #(
        .DIGITS     (DIGITS),
        .PRESCALE_W (PRESCALE_W),
        .GUARD      (GUARD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
        .hold     (hold),
        .blank_lz (blank_lz),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .an_n     (an_n),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frm;
    } exp_t;

    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: clocks elapsed since reset release and the
    // value the display is currently committed to.
    int          m_t    = 0;
    logic [31:0] m_snap = 32'h0;

    logic [6:0] font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // Expected response of the next active edge, derived from elapsed time:
    // position in frame = t mod FRAME_LEN, digit = position / DWELL.
    task automatic model_push();
        exp_t        e;
        int          pos;
        int          dig;
        int          ph;
        logic [31:0] upper;
        if (!rst_n) begin
            e.an   = 8'hFF;
            e.seg  = 7'h7F;
            e.dp   = 1'b1;
            e.frm  = 1'b0;
            m_t    = 0;
            m_snap = 32'h0;
        end else begin
            pos   = m_t % FRAME_LEN;
            dig   = pos / DWELL;
            ph    = pos % DWELL;
            upper = m_snap >> (4 * dig);
            e.an  = (ph < GUARD) ? 8'hFF : ~(8'h01 << dig);
            if (blank_lz && dig != 0 && upper == 32'h0) e.seg = 7'h7F;
            else e.seg = font[upper[3:0]];
            e.dp  = !(dig == 0 && hold);
            e.frm = (pos == FRAME_LEN - 1);
            if (pos == FRAME_LEN - 1 && !hold) m_snap = data;
            m_t++;
        end
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic [31:0] d, input logic h, input logic b);
        @(negedge clk);
        rst_n    = r;
        data     = d;
        hold     = h;
        blank_lz = b;
        model_push();
    endtask

    task automatic run(input int n, input logic [31:0] d, input logic h, input logic b);
        for (int i = 0; i < n; i++) step(1'b1, d, h, b);
    endtask

    function automatic logic [31:0] rand_data();
        int          nz;
        logic [31:0] mask;
        nz   = $urandom_range(0, 8);
        mask = (nz == 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * nz)) - 32'h1);
        return $urandom & mask;
    endfunction

    // Monitor: the display presents a new output every clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("an_n",  32'(an_n),  32'(e.an));
                check("seg_n", 32'(seg_n), 32'(e.seg));
                check("dp_n",  32'(dp_n),  32'(e.dp));
                check("frame", 32'(frame), 32'(e.frm));
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic        h;
        logic        b;

        // Reset held with a live value on data
        for (int i = 0; i < 3; i++) step(1'b0, 32'h12345678, 1'b0, 1'b0);
        // First frame shows zeros, second frame shows 12345678
        run(3 * FRAME_LEN, 32'h12345678, 1'b0, 1'b0);
        // Scan walk and guard with alternating digits
        run(2 * FRAME_LEN, 32'hA5A5A5A5, 1'b0, 1'b0);
        // Frame consistency across a mid-frame data change
        run(FRAME_LEN + 12, 32'h0, 1'b0, 1'b0);
        run(2 * FRAME_LEN, 32'hFFFFFFFF, 1'b0, 1'b0);
        // Hold freezes DEADBEEF while data goes to zero
        run(2 * FRAME_LEN, 32'hDEADBEEF, 1'b0, 1'b0);
        run(3 * FRAME_LEN, 32'h0, 1'b1, 1'b0);
        run(2 * FRAME_LEN, 32'h0, 1'b0, 1'b0);
        // Leading-zero blanking
        run(2 * FRAME_LEN, 32'h00000A00, 1'b0, 1'b1);
        run(2 * FRAME_LEN, 32'h0, 1'b0, 1'b1);

        // Randomized traffic
        d = rand_data();
        h = 1'b0;
        b = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0)  d = rand_data();
            if ($urandom_range(0, 49) == 0) h = ~h;
            if ($urandom_range(0, 29) == 0) b = ~b;
            step(1'b1, d, h, b);
        end

        // Reset mid-frame once the scan registers hold idx = 5, cnt = 2
        h = 1'b0;
        do begin
            step(1'b1, 32'hCAFE0123, h, 1'b1);
        end while ((m_t % FRAME_LEN) != 5 * DWELL + 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_an_n",  32'(an_n),  32'hFF);
        check("async_rst_seg_n", 32'(seg_n), 32'h7F);
        check("async_rst_dp_n",  32'(dp_n),  32'h1);
        check("async_rst_frame", 32'(frame), 32'h0);
        for (int i = 0; i < 2; i++) step(1'b0, 32'hCAFE0123, 1'b0, 1'b1);
        run(3 * FRAME_LEN, 32'hCAFE0123, 1'b0, 1'b1);
        run(FRAME_LEN, 32'h00F00000, 1'b0, 1'b1);

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
